// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (instruction fetch, load/store),
// the arbiter and the downstream memory/MMIO port.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    // instruction-fetch requester
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_resp_valid;
    logic              if_resp_ready;
    logic [DATA_W-1:0] if_resp_data;

    // load/store requester
    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [ADDR_W-1:0] ls_req_addr;
    logic              ls_req_wen;
    logic [DATA_W-1:0] ls_req_wdata;
    logic [3:0]        ls_req_wdt;
    logic              ls_resp_valid;
    logic              ls_resp_ready;
    logic [DATA_W-1:0] ls_resp_data;

    // downstream memory port
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_ren;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        wdt_op;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  if_req_valid, if_req_addr, if_resp_ready,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wdt, ls_resp_ready,
        output ls_req_ready, ls_resp_valid, ls_resp_data,
        output mem_raddr, mem_waddr, mem_ren, mem_wen, mem_wdata, wdt_op,
        input  mem_rdata
    );

    // requester + memory side
    modport master (
        output if_req_valid, if_req_addr, if_resp_ready,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wdt, ls_resp_ready,
        input  ls_req_ready, ls_resp_valid, ls_resp_data,
        input  mem_raddr, mem_waddr, mem_ren, mem_wen, mem_wdata, wdt_op,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and load/store share one
// downstream port. Round-robin on ties, one transaction in flight.
//
// state  | meaning
// IDLE   | no transaction; grant one requester if any is valid
// ACCESS | one-cycle downstream strobe with latched request, capture read data
// RESP   | owner's resp_valid held until its resp_ready
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wdt_q, wdt_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic grant_if;
    logic grant_ls;
    logic resp_hs;

    // Round-robin arbitration; no grant while reset is asserted.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (bus.if_req_valid && bus.ls_req_valid) begin
                if (last_grant_q == OWNER_IF) begin
                    grant_ls = 1'b1;
                end else begin
                    grant_if = 1'b1;
                end
            end else begin
                grant_if = bus.if_req_valid;
                grant_ls = bus.ls_req_valid;
            end
        end
    end

    assign resp_hs = (state_q == RESP) &&
                     ((owner_q == OWNER_LS) ? bus.ls_resp_ready : bus.if_resp_ready);

    // Next-state and transaction capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wdt_d        = wdt_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    owner_d      = OWNER_LS;
                    addr_d       = bus.ls_req_addr;
                    wen_d        = bus.ls_req_wen;
                    wdata_d      = bus.ls_req_wdata;
                    wdt_d        = bus.ls_req_wdt;
                    last_grant_d = OWNER_LS;
                    state_d      = ACCESS;
                end else if (grant_if) begin
                    // fetches are plain reads with no payload
                    owner_d      = OWNER_IF;
                    addr_d       = bus.if_req_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wdt_d        = '0;
                    last_grant_d = OWNER_IF;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                resp_data_d = wen_q ? '0 : bus.mem_rdata;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= OWNER_IF;
            owner_q      <= OWNER_IF;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wdt_q        <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wdt_q        <= wdt_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.if_req_ready  = grant_if;
    assign bus.ls_req_ready  = grant_ls;

    assign bus.if_resp_valid = (state_q == RESP) && (owner_q == OWNER_IF);
    assign bus.ls_resp_valid = (state_q == RESP) && (owner_q == OWNER_LS);
    assign bus.if_resp_data  = bus.if_resp_valid ? resp_data_q : '0;
    assign bus.ls_resp_data  = bus.ls_resp_valid ? resp_data_q : '0;

    // Both address ports carry the latched address; strobes only in ACCESS.
    assign bus.mem_raddr = addr_q;
    assign bus.mem_waddr = addr_q;
    assign bus.mem_ren   = (state_q == ACCESS) && !wen_q;
    assign bus.mem_wen   = (state_q == ACCESS) && wen_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.wdt_op    = wdt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (grant rule, latency arithmetic, memory map).
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural memory contents, combinational on the read address
    function automatic logic [63:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0010) return 64'h1122_3344_5566_7788;
        return {a ^ 32'h5a5a_5a5a, ~a};
    endfunction

    assign bus.mem_rdata = mem_fn(bus.mem_raddr);

    function automatic logic [265:0] all_outs();
        return {bus.if_req_ready, bus.if_resp_valid, bus.if_resp_data,
                bus.ls_req_ready, bus.ls_resp_valid, bus.ls_resp_data,
                bus.mem_raddr, bus.mem_waddr, bus.mem_ren, bus.mem_wen,
                bus.mem_wdata, bus.wdt_op};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.if_req_valid  = 1'b0;
        bus.if_req_addr   = '0;
        bus.if_resp_ready = 1'b1;
        bus.ls_req_valid  = 1'b0;
        bus.ls_req_addr   = '0;
        bus.ls_req_wen    = 1'b0;
        bus.ls_req_wdata  = '0;
        bus.ls_req_wdt    = '0;
        bus.ls_resp_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        step();
        step();
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_tie: if/ls ready got %b want 01",
                     {bus.if_req_ready, bus.ls_req_ready});
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        step();
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_idle_after: got %h want 0", all_outs());
        end
    endtask

    task automatic test_load();
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 32'h8000_0010;
        bus.ls_req_wen   = 1'b0;
        bus.ls_req_wdata = {$urandom, $urandom};
        bus.ls_req_wdt   = 4'h3;
        #1;
        checks++;
        if (bus.ls_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_grant: ls_req_ready got %b want 1", bus.ls_req_ready);
        end
        step();
        bus.ls_req_valid = 1'b0;
        bus.ls_req_addr  = $urandom;
        bus.ls_req_wen   = 1'b1;
        bus.ls_req_wdt   = 4'hf;
        #1;
        checks++;
        if ({bus.mem_ren, bus.mem_wen, bus.mem_raddr, bus.mem_waddr, bus.wdt_op, bus.ls_resp_valid}
            !== {1'b1, 1'b0, 32'h8000_0010, 32'h8000_0010, 4'h3, 1'b0}) begin
            errors++;
            $display("FAIL load_strobe: ren=%b wen=%b raddr=%h waddr=%h wdt=%h rv=%b want 1 0 80000010 80000010 3 0",
                     bus.mem_ren, bus.mem_wen, bus.mem_raddr, bus.mem_waddr, bus.wdt_op, bus.ls_resp_valid);
        end
        step();
        #1;
        checks++;
        if ({bus.ls_resp_valid, bus.ls_resp_data, bus.mem_ren, bus.if_resp_valid}
            !== {1'b1, 64'h1122_3344_5566_7788, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_resp: valid=%b data=%h ren=%b if_rv=%b want 1 1122334455667788 0 0",
                     bus.ls_resp_valid, bus.ls_resp_data, bus.mem_ren, bus.if_resp_valid);
        end
        step();
        #1;
        checks++;
        if (bus.ls_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_done: ls_resp_valid got %b want 0", bus.ls_resp_valid);
        end
    endtask

    task automatic test_store();
        int wen_cycles;
        wen_cycles = 0;
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 32'ha000_03f8;
        bus.ls_req_wen   = 1'b1;
        bus.ls_req_wdata = 64'h1234_5678;
        bus.ls_req_wdt   = 4'h2;
        #1;
        checks++;
        if (bus.ls_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_grant: ls_req_ready got %b want 1", bus.ls_req_ready);
        end
        step();
        bus.ls_req_valid = 1'b0;
        bus.ls_req_wdata = {$urandom, $urandom};
        #1;
        checks++;
        if ({bus.mem_wen, bus.mem_ren, bus.mem_waddr, bus.mem_raddr, bus.mem_wdata, bus.wdt_op}
            !== {1'b1, 1'b0, 32'ha000_03f8, 32'ha000_03f8, 64'h1234_5678, 4'h2}) begin
            errors++;
            $display("FAIL store_strobe: wen=%b ren=%b waddr=%h raddr=%h wdata=%h wdt=%h want 1 0 a00003f8 a00003f8 12345678 2",
                     bus.mem_wen, bus.mem_ren, bus.mem_waddr, bus.mem_raddr, bus.mem_wdata, bus.wdt_op);
        end
        if (bus.mem_wen === 1'b1) wen_cycles++;
        step();
        #1;
        if (bus.mem_wen === 1'b1) wen_cycles++;
        checks++;
        if ({bus.ls_resp_valid, bus.ls_resp_data} !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL store_resp: valid=%b data=%h want 1 0", bus.ls_resp_valid, bus.ls_resp_data);
        end
        step();
        #1;
        if (bus.mem_wen === 1'b1) wen_cycles++;
        checks++;
        if (wen_cycles !== 1) begin
            errors++;
            $display("FAIL store_wen_count: got %0d want 1", wen_cycles);
        end
    endtask

    task automatic test_round_robin();
        int  order[$];
        int  overlap;
        logic [3:0] got;
        overlap = 0;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h0000_1000;
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 32'h0000_2000;
        bus.ls_req_wen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.mem_ren && bus.mem_wen) overlap++;
            if (bus.if_req_ready && bus.ls_req_ready) overlap++;
            if (bus.ls_req_ready) order.push_back(1);
            else if (bus.if_req_ready) order.push_back(0);
            if (order.size() >= 4) break;
            step();
        end
        step();
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.mem_ren && bus.mem_wen) overlap++;
            step();
        end
        got = '0;
        for (int i = 0; i < 4 && i < order.size(); i++) got[3-i] = order[i][0];
        checks++;
        if (order.size() !== 4 || got !== 4'b1010) begin
            errors++;
            $display("FAIL rr_order: grants=%0d order(ls=1)=%b want 4 grants 1010", order.size(), got);
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL rr_overlap: got %0d want 0", overlap);
        end
    endtask

    task automatic test_backpressure();
        bus.if_resp_ready = 1'b0;
        bus.if_req_valid  = 1'b1;
        bus.if_req_addr   = 32'h0000_3000;
        #1;
        checks++;
        if ({bus.if_req_ready, bus.ls_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_if_grant: if/ls ready got %b want 10", {bus.if_req_ready, bus.ls_req_ready});
        end
        step();
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = 32'hdead_0000;
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 32'h0000_4000;
        bus.ls_req_wen   = 1'b0;
        #1;
        checks++;
        if ({bus.mem_ren, bus.mem_raddr, bus.ls_req_ready} !== {1'b1, 32'h0000_3000, 1'b0}) begin
            errors++;
            $display("FAIL bp_fetch_strobe: ren=%b raddr=%h ls_ready=%b want 1 00003000 0",
                     bus.mem_ren, bus.mem_raddr, bus.ls_req_ready);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({bus.if_resp_valid, bus.if_resp_data, bus.ls_req_ready, bus.ls_resp_valid}
                !== {1'b1, mem_fn(32'h0000_3000), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: if_rv=%b data=%h ls_ready=%b ls_rv=%b want 1 %h 0 0",
                         i, bus.if_resp_valid, bus.if_resp_data, bus.ls_req_ready, bus.ls_resp_valid,
                         mem_fn(32'h0000_3000));
            end
            step();
        end
        bus.if_resp_ready = 1'b1;
        #1;
        checks++;
        if ({bus.if_resp_valid, bus.ls_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: if_rv/ls_ready got %b want 10", {bus.if_resp_valid, bus.ls_req_ready});
        end
        step();
        #1;
        checks++;
        if ({bus.ls_req_ready, bus.if_resp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_ls_grant: ls_ready/if_rv got %b want 10", {bus.ls_req_ready, bus.if_resp_valid});
        end
        step();
        bus.ls_req_valid = 1'b0;
        step();
        #1;
        checks++;
        if ({bus.ls_resp_valid, bus.ls_resp_data} !== {1'b1, mem_fn(32'h0000_4000)}) begin
            errors++;
            $display("FAIL bp_ls_resp: valid=%b data=%h want 1 %h",
                     bus.ls_resp_valid, bus.ls_resp_data, mem_fn(32'h0000_4000));
        end
        step();
    endtask

    task automatic test_reset_abort();
        bus.ls_req_valid = 1'b1;
        bus.ls_req_addr  = 32'h0000_5000;
        bus.ls_req_wen   = 1'b1;
        bus.ls_req_wdata = {$urandom, $urandom};
        bus.ls_req_wdt   = 4'h5;
        #1;
        step();
        bus.ls_req_valid = 1'b0;
        #1;
        checks++;
        if (bus.mem_wen !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_access: mem_wen got %b want 1", bus.mem_wen);
        end
        rst = 1'b1;
        step();
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %h want 0", all_outs());
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            checks++;
            if ({bus.ls_resp_valid, bus.if_resp_valid, bus.mem_ren, bus.mem_wen} !== 4'b0) begin
                errors++;
                $display("FAIL abort_quiet[%0d]: ls_rv/if_rv/ren/wen got %b want 0000", i,
                         {bus.ls_resp_valid, bus.if_resp_valid, bus.mem_ren, bus.mem_wen});
            end
        end
    endtask

    // Transaction-level model: free/busy, grant cycle, round-robin memory.
    task automatic test_random();
        bit          busy, last_ls, t_ls, t_wen, if_acc, ls_acc;
        int          g;
        logic [31:0] t_addr;
        logic [63:0] t_wdata, e_data;
        logic [3:0]  t_wdt;
        bit          e_if_rdy, e_ls_rdy, e_ren, e_wen, e_if_rv, e_ls_rv;
        busy = 0; last_ls = 0; if_acc = 0; ls_acc = 0; g = 0;
        t_ls = 0; t_wen = 0; t_addr = '0; t_wdata = '0; t_wdt = '0;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            if (if_acc) begin bus.if_req_valid = 1'b0; bus.if_req_addr = $urandom; if_acc = 0; end
            if (ls_acc) begin
                bus.ls_req_valid = 1'b0; bus.ls_req_addr = $urandom;
                bus.ls_req_wen = $urandom; bus.ls_req_wdata = {$urandom, $urandom};
                bus.ls_req_wdt = $urandom; ls_acc = 0;
            end
            if (!bus.if_req_valid && $urandom_range(0, 2) == 0) begin
                bus.if_req_valid = 1'b1;
                bus.if_req_addr  = $urandom;
            end
            if (!bus.ls_req_valid && $urandom_range(0, 2) == 0) begin
                bus.ls_req_valid = 1'b1;
                bus.ls_req_addr  = $urandom;
                bus.ls_req_wen   = $urandom;
                bus.ls_req_wdata = {$urandom, $urandom};
                bus.ls_req_wdt   = $urandom;
            end
            bus.if_resp_ready = $urandom;
            bus.ls_resp_ready = $urandom;
            #1;
            e_if_rdy = !busy && bus.if_req_valid && (!bus.ls_req_valid || last_ls);
            e_ls_rdy = !busy && bus.ls_req_valid && (!bus.if_req_valid || !last_ls);
            e_ren    = busy && (c == g + 1) && !t_wen;
            e_wen    = busy && (c == g + 1) && t_wen;
            e_if_rv  = busy && (c >= g + 2) && !t_ls;
            e_ls_rv  = busy && (c >= g + 2) && t_ls;
            e_data   = t_wen ? 64'h0 : mem_fn(t_addr);
            checks++;
            if ({bus.if_req_ready, bus.ls_req_ready} !== {e_if_rdy, e_ls_rdy}) begin
                errors++;
                $display("FAIL rnd_ready c=%0d: if/ls got %b want %b", c,
                         {bus.if_req_ready, bus.ls_req_ready}, {e_if_rdy, e_ls_rdy});
            end
            checks++;
            if ({bus.mem_ren, bus.mem_wen} !== {e_ren, e_wen}) begin
                errors++;
                $display("FAIL rnd_strobe c=%0d: ren/wen got %b want %b", c,
                         {bus.mem_ren, bus.mem_wen}, {e_ren, e_wen});
            end
            if (e_ren || e_wen) begin
                checks++;
                if ({bus.mem_raddr, bus.mem_waddr} !== {t_addr, t_addr}) begin
                    errors++;
                    $display("FAIL rnd_addr c=%0d: raddr=%h waddr=%h want %h", c,
                             bus.mem_raddr, bus.mem_waddr, t_addr);
                end
            end
            if (e_wen) begin
                checks++;
                if ({bus.mem_wdata, bus.wdt_op} !== {t_wdata, t_wdt}) begin
                    errors++;
                    $display("FAIL rnd_wdata c=%0d: wdata=%h wdt=%h want %h %h", c,
                             bus.mem_wdata, bus.wdt_op, t_wdata, t_wdt);
                end
            end
            checks++;
            if ({bus.if_resp_valid, bus.ls_resp_valid} !== {e_if_rv, e_ls_rv}) begin
                errors++;
                $display("FAIL rnd_resp_valid c=%0d: if/ls got %b want %b", c,
                         {bus.if_resp_valid, bus.ls_resp_valid}, {e_if_rv, e_ls_rv});
            end
            if (e_if_rv) begin
                checks++;
                if (bus.if_resp_data !== e_data) begin
                    errors++;
                    $display("FAIL rnd_if_data c=%0d: got %h want %h", c, bus.if_resp_data, e_data);
                end
            end
            if (e_ls_rv) begin
                checks++;
                if (bus.ls_resp_data !== e_data) begin
                    errors++;
                    $display("FAIL rnd_ls_data c=%0d: got %h want %h", c, bus.ls_resp_data, e_data);
                end
            end
            if (!busy && (e_if_rdy || e_ls_rdy)) begin
                busy    = 1;
                g       = c;
                t_ls    = e_ls_rdy;
                t_addr  = e_ls_rdy ? bus.ls_req_addr : bus.if_req_addr;
                t_wen   = e_ls_rdy ? bus.ls_req_wen : 1'b0;
                t_wdata = bus.ls_req_wdata;
                t_wdt   = bus.ls_req_wdt;
                last_ls = e_ls_rdy;
                if_acc  = e_if_rdy;
                ls_acc  = e_ls_rdy;
            end else if (busy && c >= g + 2 && (t_ls ? bus.ls_resp_ready : bus.if_resp_ready)) begin
                busy = 0;
            end
            step();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_load();
        test_store();
        test_round_robin();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request/downstream address width.
REQ-002 SHALL have parameter DATA_W, default 64, read/write data width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port if_req_valid  in  1  instruction-fetch read request.
REQ-006 SHALL have port if_req_ready  out  1  IF request accepted this cycle.
REQ-007 SHALL have port if_req_addr  in  ADDR_W  IF read address.
REQ-008 SHALL have port if_resp_valid  out  1  IF read data valid.
REQ-009 SHALL have port if_resp_ready  in  1  IF consumes response.
REQ-010 SHALL have port if_resp_data  out  DATA_W  IF read data.
REQ-011 SHALL have port ls_req_valid  in  1  load/store request.
REQ-012 SHALL have port ls_req_ready  out  1  LS request accepted this cycle.
REQ-013 SHALL have port ls_req_addr  in  ADDR_W  LS address.
REQ-014 SHALL have port ls_req_wen  in  1  1 = store, 0 = load.
REQ-015 SHALL have port ls_req_wdata  in  DATA_W  store data.
REQ-016 SHALL have port ls_req_wdt  in  4  access-size/width op code, passed through unchanged.
REQ-017 SHALL have port ls_resp_valid  out  1  LS completion (load data or store ack).
REQ-018 SHALL have port ls_resp_ready  in  1  LS consumes response.
REQ-019 SHALL have port ls_resp_data  out  DATA_W  load data; 0 for stores.
REQ-020 SHALL have ports mem_raddr, mem_waddr  out  ADDR_W  downstream memory/MMIO addresses.
REQ-021 SHALL have ports mem_ren, mem_wen  out  1  downstream one-cycle strobes; mem_wdata  out  DATA_W; wdt_op  out  4.
REQ-022 SHALL have port mem_rdata  in  DATA_W  downstream combinational read data, valid in the cycle mem_ren is high.

Function
REQ-023 SHALL use FSM states IDLE, ACCESS, RESP; exactly one transaction outstanding.
REQ-024 In IDLE, if_req_ready/ls_req_ready SHALL be high only for the requester granted this cycle; both low in ACCESS and RESP.
REQ-025 Arbitration SHALL be round-robin via a last_grant bit: both valid -> grant the one not granted last; one valid -> grant it.
REQ-026 On grant (valid&&ready), SHALL latch requester id, addr, wen, wdata, wdt, update last_grant, go to ACCESS.
REQ-027 In ACCESS, SHALL drive exactly one cycle of mem_ren (load/fetch) or mem_wen (store) with latched addr on both mem_raddr and mem_waddr, then go to RESP.
REQ-028 In ACCESS, SHALL capture mem_rdata into the response register for reads; stores capture 0.
REQ-029 In RESP, the owner's resp_valid SHALL be high and data stable until its resp_ready; on handshake -> IDLE.
REQ-030 Latency SHALL be: grant cycle N, downstream strobe N+1, resp_valid N+2 (resp_ready high at N+2 -> next grant possible at N+3).
REQ-031 The non-owner's resp_valid SHALL stay 0; mem_ren and mem_wen SHALL never be high together or outside ACCESS.
REQ-032 Request inputs changing after grant SHALL not affect the in-flight transaction.
REQ-033 A requester with resp_valid held (backpressure) SHALL block all new grants; the other's request waits (valid held, no drop).

Reset
REQ-034 While rst=1 at posedge: state IDLE, last_grant = IF (so LS wins the first tie), all outputs 0 including strobes, readies, resp_valid, resp_data; reset mid-transaction SHALL abort it with no further strobe.

Verification
REQ-035 LS load addr 0x80000010, mem_rdata=0x1122334455667788 -> mem_ren high exactly at N+1, ls_resp_valid at N+2 with that data.
REQ-036 IF and LS valid together from reset, both held -> grants LS, IF, LS, IF in order; no strobe overlap.
REQ-037 LS store addr 0xa00003f8, wdata=0x12345678, wdt=0x2 -> single mem_wen cycle with those values; ls_resp_valid, ls_resp_data=0.
REQ-038 if_resp_ready low for 5 cycles with LS valid waiting -> if_resp_valid/data held, no LS grant until IF handshake.
REQ-039 rst asserted during ACCESS -> next cycle all outputs 0, state IDLE, no resp_valid issued for aborted transaction.
